// File: rtl/dm_cache_fsm.sv
`default_nettype none
// ============================================================================
// Module   : dm_cache_fsm
// Purpose  : Controller for a direct-mapped write-back cache. Accepts one CPU
//            word request at a time, looks up the tag memory, serves hits from
//            the 512 x 256-bit data memory, writes back dirty victims and
//            allocates missing lines from main memory.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            cpu_req_* / cpu_res_*      - CPU load/store request and response
//            mem_req_* / mem_ready/data - main-memory line request handshake
//            tag_* / data_*             - tag and data memory index/write/read
//            hit_count, miss_count      - statistics counters
// Config   : CACHE_STATS_EN - when defined, hit/miss counters are built;
//            otherwise the counter ports are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module dm_cache_fsm (
    input  logic         clk,
    input  logic         rst,
    input  logic         cpu_req_valid,
    input  logic         cpu_req_rw,
    input  logic [31:0]  cpu_req_addr,
    input  logic [31:0]  cpu_req_data,
    output logic         cpu_res_ready,
    output logic [31:0]  cpu_res_data,
    output logic         mem_req_valid,
    output logic         mem_req_rw,
    output logic [31:0]  mem_req_addr,
    output logic [255:0] mem_req_data,
    input  logic         mem_ready,
    input  logic [255:0] mem_data,
    output logic [8:0]   tag_index,
    output logic         tag_we,
    output logic [19:0]  tag_write,
    input  logic [19:0]  tag_read,
    output logic [8:0]   data_index,
    output logic         data_we,
    output logic [255:0] data_write,
    input  logic [255:0] data_read,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_COMPARE_TAG = 2'd1,
        S_WRITE_BACK  = 2'd2,
        S_ALLOCATE    = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_next;

    // Latched request; the byte offset is never needed so it is not stored.
    logic         r_req_rw;
    logic [31:2]  r_req_addr;
    logic [31:0]  r_req_data;
    logic [31:0]  r_res_data;

    logic [17:0]  w_req_tag;
    logic [8:0]   w_req_index;
    logic [2:0]   w_req_word;
    logic [7:0]   w_bit_base;
    logic         w_tag_valid;
    logic         w_tag_dirty;
    logic [17:0]  w_tag_tag;
    logic         w_hit;
    logic [31:0]  w_read_word;
    logic [255:0] w_merged_line;
    logic         w_unused_addr_lsb;

    assign w_req_tag   = r_req_addr[31:14];
    assign w_req_index = r_req_addr[13:5];
    assign w_req_word  = r_req_addr[4:2];
    assign w_bit_base  = {w_req_word, 5'b00000};

    assign w_tag_valid = tag_read[19];
    assign w_tag_dirty = tag_read[18];
    assign w_tag_tag   = tag_read[17:0];
    assign w_hit       = w_tag_valid && (w_tag_tag == w_req_tag);

    assign w_read_word = data_read[w_bit_base +: 32];

    assign tag_index   = w_req_index;
    assign data_index  = w_req_index;

    assign w_unused_addr_lsb = ^cpu_req_addr[1:0];

    always_comb begin
        w_merged_line = data_read;
        w_merged_line[w_bit_base +: 32] = r_req_data;
    end

    // ------------------------------------------------------------------------
    // State register and request latch
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_req_rw   <= 1'b0;
            r_req_addr <= '0;
            r_req_data <= '0;
            r_res_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && cpu_req_valid) begin
                r_req_rw   <= cpu_req_rw;
                r_req_addr <= cpu_req_addr[31:2];
                r_req_data <= cpu_req_data;
            end
            if (r_state == S_COMPARE_TAG && w_hit && !r_req_rw) begin
                r_res_data <= w_read_word;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        cpu_res_ready = 1'b0;
        cpu_res_data  = r_res_data;
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        tag_we        = 1'b0;
        tag_write     = '0;
        data_we       = 1'b0;
        data_write    = '0;

        case (r_state)
            S_IDLE: begin
                if (cpu_req_valid) begin
                    w_state_next = S_COMPARE_TAG;
                end
            end

            S_COMPARE_TAG: begin
                if (w_hit) begin
                    cpu_res_ready = 1'b1;
                    w_state_next  = S_IDLE;
                    if (r_req_rw) begin
                        data_we    = 1'b1;
                        data_write = w_merged_line;
                        tag_we     = 1'b1;
                        tag_write  = {1'b1, 1'b1, w_req_tag};
                    end else begin
                        cpu_res_data = w_read_word;
                    end
                end else if (w_tag_valid && w_tag_dirty) begin
                    w_state_next = S_WRITE_BACK;
                end else begin
                    w_state_next = S_ALLOCATE;
                end
            end

            S_WRITE_BACK: begin
                // Victim address is rebuilt from the stored tag, not the request.
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = {w_tag_tag, w_req_index, 5'b00000};
                mem_req_data  = data_read;
                if (mem_ready) begin
                    w_state_next = S_ALLOCATE;
                end
            end

            S_ALLOCATE: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b0;
                mem_req_addr  = {w_req_tag, w_req_index, 5'b00000};
                if (mem_ready) begin
                    data_we      = 1'b1;
                    data_write   = mem_data;
                    tag_we       = 1'b1;
                    tag_write    = {1'b1, 1'b0, w_req_tag};
                    w_state_next = S_COMPARE_TAG;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // A memory response landing in the reset cycle must not modify the
        // tag or data arrays; the request is simply abandoned.
        if (rst) begin
            tag_we  = 1'b0;
            data_we = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------------
`ifdef CACHE_STATS_EN
    // Set on acceptance, cleared after the first COMPARE_TAG so that the
    // post-allocate lookup is not counted.
    logic        r_first_lookup;
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_first_lookup <= 1'b0;
            r_hit_count    <= '0;
            r_miss_count   <= '0;
        end else begin
            if (r_state == S_IDLE && cpu_req_valid) begin
                r_first_lookup <= 1'b1;
            end else if (r_state == S_COMPARE_TAG) begin
                r_first_lookup <= 1'b0;
            end
            if (r_state == S_COMPARE_TAG && r_first_lookup) begin
                if (w_hit) begin
                    r_hit_count <= r_hit_count + 32'd1;
                end else begin
                    r_miss_count <= r_miss_count + 32'd1;
                end
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_cache_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_cache_fsm
// Purpose  : Self-checking bench for dm_cache_fsm with tag/data RAM models,
//            a delayed main-memory responder and a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_cache_fsm;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req_valid;
    logic         cpu_req_rw;
    logic [31:0]  cpu_req_addr;
    logic [31:0]  cpu_req_data;
    logic         cpu_res_ready;
    logic [31:0]  cpu_res_data;
    logic         mem_req_valid;
    logic         mem_req_rw;
    logic [31:0]  mem_req_addr;
    logic [255:0] mem_req_data;
    logic         mem_ready;
    logic [255:0] mem_data;
    logic [8:0]   tag_index;
    logic         tag_we;
    logic [19:0]  tag_write;
    logic [19:0]  tag_read;
    logic [8:0]   data_index;
    logic         data_we;
    logic [255:0] data_write;
    logic [255:0] data_read;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    always #5 clk = ~clk;

    dm_cache_fsm dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_rw    (cpu_req_rw),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_req_data  (cpu_req_data),
        .cpu_res_ready (cpu_res_ready),
        .cpu_res_data  (cpu_res_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_rw    (mem_req_rw),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_ready     (mem_ready),
        .mem_data      (mem_data),
        .tag_index     (tag_index),
        .tag_we        (tag_we),
        .tag_write     (tag_write),
        .tag_read      (tag_read),
        .data_index    (data_index),
        .data_we       (data_we),
        .data_write    (data_write),
        .data_read     (data_read),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- tag / data RAM models ----------------
    logic [19:0]  tag_mem  [512];
    logic [255:0] data_mem [512];
    logic         mem_clear;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 512; i++) begin
                tag_mem[i]  <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            if (tag_we)  tag_mem[tag_index]   <= tag_write;
            if (data_we) data_mem[data_index] <= data_write;
        end
    end

    assign tag_read  = tag_mem[tag_index];
    assign data_read = data_mem[data_index];

    // ---------------- reference contents ----------------
    function automatic logic [255:0] init_line(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = la ^ (32'h9E3779B1 * (w + 1));
        if (la == 32'h0000_1000) l[63:32] = 32'hDEADBEEF;
        return l;
    endfunction

    logic [255:0] main_mem [logic [31:0]];   // written only by the responder
    logic [255:0] ref_mem  [logic [31:0]];   // written only by the test sequence

    function automatic logic [255:0] main_line(input logic [31:0] la);
        return main_mem.exists(la) ? main_mem[la] : init_line(la);
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] la);
        return ref_mem.exists(la) ? ref_mem[la] : init_line(la);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [255:0] l;
        l = ref_line({a[31:5], 5'b0});
        return l[int'(a[4:2])*32 +: 32];
    endfunction

    // ---------------- main-memory responder ----------------
    typedef struct packed {
        logic         rw;
        logic [31:0]  addr;
        logic [255:0] data;
    } mreq_t;

    mreq_t mlog[$];
    mreq_t cur_req;
    int    mem_delay    = 1;
    int    mem_cnt      = 0;
    int    mem_unstable = 0;

    initial begin
        mem_ready = 1'b0;
        mem_data  = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (mem_req_valid) begin
                mem_cnt++;
                if (mem_cnt == 1) begin
                    cur_req = '{mem_req_rw, mem_req_addr, mem_req_data};
                    mlog.push_back(cur_req);
                end else if ({mem_req_rw, mem_req_addr, mem_req_data} !== cur_req) begin
                    mem_unstable++;
                end
                if (mem_cnt >= mem_delay) begin
                    if (mem_req_rw) main_mem[mem_req_addr] = mem_req_data;
                    else            mem_data = main_line(mem_req_addr);
                    mem_ready = 1'b1;
                    mem_cnt   = 0;
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        rw;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    task automatic issue(input logic rw, input logic [31:0] addr, input logic [31:0] data);
        exp_t         e;
        logic [255:0] l;
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_rw    = rw;
        cpu_req_addr  = addr;
        cpu_req_data  = data;
        e.rw   = rw;
        e.data = rw ? 32'd0 : ref_word(addr);
        if (rw) begin
            l = ref_line({addr[31:5], 5'b0});
            l[int'(addr[4:2])*32 +: 32] = data;
            ref_mem[{addr[31:5], 5'b0}] = l;
        end
        exp_q.push_back(e);
        @(negedge clk);
        // Inputs after acceptance must be ignored: drive garbage.
        cpu_req_valid = 1'b0;
        cpu_req_rw    = ~rw;
        cpu_req_addr  = $urandom;
        cpu_req_data  = $urandom;
    endtask

    task automatic wait_res(input int max_cyc, output int lat, output logic [31:0] d,
                            output logic ok);
        ok  = 1'b0;
        lat = 0;
        d   = '0;
        for (int c = 1; c <= max_cyc; c++) begin
            #2;
            if (cpu_res_ready) begin
                ok  = 1'b1;
                lat = c;
                d   = cpu_res_data;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        #2;
        total++;
        if ({cpu_res_ready, mem_req_valid, mem_req_rw, tag_we, data_we} !== 5'b0) begin
            bad++;
            $display("FAIL reset_strobes got=%b exp=00000",
                     {cpu_res_ready, mem_req_valid, mem_req_rw, tag_we, data_we});
        end
        total++;
        if ({cpu_res_data, mem_req_addr, tag_write, tag_index, data_index} !== '0) begin
            bad++;
            $display("FAIL reset_fields res_data=%h mem_addr=%h tag_write=%h idx=%h/%h exp=0",
                     cpu_res_data, mem_req_addr, tag_write, tag_index, data_index);
        end
        total++;
        if ({mem_req_data, data_write} !== '0) begin
            bad++;
            $display("FAIL reset_lines mem_req_data/data_write nonzero, exp=0");
        end
        total++;
        if ({hit_count, miss_count} !== 64'd0) begin
            bad++;
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", hit_count, miss_count);
        end
        rst = 1'b0;
        @(negedge clk);
        #2;
        total++;
        if ({cpu_res_ready, mem_req_valid, tag_we, data_we} !== 4'b0) begin
            bad++;
            $display("FAIL idle_quiet got=%b exp=0000",
                     {cpu_res_ready, mem_req_valid, tag_we, data_we});
        end
    endtask

    task automatic test_cold_read();
        int lat; logic [31:0] d; logic ok; exp_t e; int base; mreq_t m;
        base = mlog.size();
        mem_delay = 2;
        issue(1'b0, 32'h0000_1004, 32'd0);
        wait_res(40, lat, d, ok);
        e = exp_q.pop_front();
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL cold_read_timeout got=no_response exp=response"); end
        total++;
        if (d !== e.data || d !== 32'hDEADBEEF) begin
            bad++; $display("FAIL cold_read_data got=%h exp=%h", d, 32'hDEADBEEF);
        end
        total++;
        if (lat !== 4) begin bad++; $display("FAIL cold_read_latency got=%0d exp=4", lat); end
        m = (mlog.size() > base) ? mlog[base] : '1;
        total++;
        if (m.rw !== 1'b0 || m.addr !== 32'h0000_1000) begin
            bad++; $display("FAIL cold_read_memreq got rw=%b addr=%h exp rw=0 addr=00001000", m.rw, m.addr);
        end
        total++;
        if (tag_mem[128] !== {1'b1, 1'b0, 18'd0}) begin
            bad++; $display("FAIL cold_read_tag got=%h exp=%h", tag_mem[128], {1'b1, 1'b0, 18'd0});
        end
    endtask

    task automatic test_read_hit();
        int lat; logic [31:0] d; logic ok; exp_t e; int base;
        base = mlog.size();
        issue(1'b0, 32'h0000_1004, 32'd0);
        wait_res(40, lat, d, ok);
        e = exp_q.pop_front();
        total++;
        if (ok !== 1'b1 || d !== e.data) begin
            bad++; $display("FAIL read_hit_data got=%h ok=%b exp=%h", d, ok, e.data);
        end
        total++;
        if (lat !== 1) begin bad++; $display("FAIL read_hit_latency got=%0d exp=1", lat); end
        total++;
        if (mlog.size() !== base) begin
            bad++; $display("FAIL read_hit_memreq got=%0d requests exp=0", mlog.size() - base);
        end
    endtask

    task automatic test_write_hit();
        int lat; logic [31:0] d; logic ok; exp_t e; int base;
        base = mlog.size();
        issue(1'b1, 32'h0000_1008, 32'h1234_5678);
        wait_res(40, lat, d, ok);
        e = exp_q.pop_front();
        total++;
        if (ok !== 1'b1 || e.rw !== 1'b1) begin bad++; $display("FAIL write_hit_done got=%b exp=1", ok); end
        total++;
        if (lat !== 1) begin bad++; $display("FAIL write_hit_latency got=%0d exp=1", lat); end
        total++;
        if (mlog.size() !== base) begin
            bad++; $display("FAIL write_hit_memreq got=%0d requests exp=0", mlog.size() - base);
        end
        @(negedge clk);
        total++;
        if (data_mem[128] !== ref_line(32'h0000_1000)) begin
            bad++; $display("FAIL write_hit_line got=%h exp=%h", data_mem[128], ref_line(32'h0000_1000));
        end
        total++;
        if (tag_mem[128] !== {1'b1, 1'b1, 18'd0}) begin
            bad++; $display("FAIL write_hit_tag got=%h exp=%h", tag_mem[128], {1'b1, 1'b1, 18'd0});
        end
    endtask

    task automatic test_dirty_miss();
        int lat; logic [31:0] d; logic ok; exp_t e; int base; mreq_t m0, m1;
        logic [255:0] exp_wb;
        base      = mlog.size();
        exp_wb    = ref_line(32'h0000_1000);
        mem_delay = 3;
        issue(1'b0, 32'h0000_5008, 32'd0);
        wait_res(60, lat, d, ok);
        e = exp_q.pop_front();
        total++;
        if (ok !== 1'b1 || d !== e.data) begin
            bad++; $display("FAIL dirty_miss_data got=%h ok=%b exp=%h", d, ok, e.data);
        end
        total++;
        if (lat !== 8) begin bad++; $display("FAIL dirty_miss_latency got=%0d exp=8", lat); end
        m0 = (mlog.size() > base)     ? mlog[base]     : '0;
        m1 = (mlog.size() > base + 1) ? mlog[base + 1] : '1;
        total++;
        if (m0.rw !== 1'b1 || m0.addr !== 32'h0000_1000) begin
            bad++; $display("FAIL dirty_miss_wb_req got rw=%b addr=%h exp rw=1 addr=00001000", m0.rw, m0.addr);
        end
        total++;
        if (m0.data !== exp_wb || m0.data[95:64] !== 32'h1234_5678) begin
            bad++; $display("FAIL dirty_miss_wb_data got word2=%h exp=12345678", m0.data[95:64]);
        end
        total++;
        if (m1.rw !== 1'b0 || m1.addr !== 32'h0000_5000) begin
            bad++; $display("FAIL dirty_miss_fill_req got rw=%b addr=%h exp rw=0 addr=00005000", m1.rw, m1.addr);
        end
        total++;
        if (tag_mem[128] !== {1'b1, 1'b0, 18'd1}) begin
            bad++; $display("FAIL dirty_miss_tag got=%h exp=%h", tag_mem[128], {1'b1, 1'b0, 18'd1});
        end
        total++;
        if (mem_unstable !== 0) begin
            bad++; $display("FAIL mem_req_stable got=%0d changes exp=0", mem_unstable);
        end
    endtask

    task automatic test_stats();
        logic [31:0] exp_h, exp_m;
`ifdef CACHE_STATS_EN
        exp_h = 32'd2;
        exp_m = 32'd2;
`else
        exp_h = 32'd0;
        exp_m = 32'd0;
`endif
        #1;
        total++;
        if (hit_count !== exp_h) begin bad++; $display("FAIL stats_hits got=%0d exp=%0d", hit_count, exp_h); end
        total++;
        if (miss_count !== exp_m) begin bad++; $display("FAIL stats_misses got=%0d exp=%0d", miss_count, exp_m); end
    endtask

    task automatic test_reset_mid_alloc();
        logic [19:0]  saved_tag;
        logic [255:0] saved_data;
        exp_t         e;
        saved_tag  = tag_mem[200];
        saved_data = data_mem[200];
        mem_delay  = 4;
        issue(1'b0, 32'h0001_D900, 32'd0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #2;
        total++;
        if (mem_req_valid !== 1'b1 || mem_req_rw !== 1'b0 || mem_req_addr !== 32'h0001_D900) begin
            bad++; $display("FAIL alloc_req got v=%b rw=%b addr=%h exp v=1 rw=0 addr=0001d900",
                            mem_req_valid, mem_req_rw, mem_req_addr);
        end
        total++;
        if ({tag_we, data_we} !== 2'b00) begin
            bad++; $display("FAIL reset_cycle_write got tag_we/data_we=%b exp=00 (mem_ready=%b)",
                            {tag_we, data_we}, mem_ready);
        end
        @(negedge clk);
        #2;
        total++;
        if ({cpu_res_ready, mem_req_valid, mem_req_rw, tag_we, data_we, cpu_res_data, mem_req_addr,
             tag_write, tag_index, hit_count, miss_count} !== '0 || {mem_req_data, data_write} !== '0) begin
            bad++; $display("FAIL post_reset_outputs got v=%b addr=%h res=%h hits=%0d misses=%0d exp=all 0",
                            mem_req_valid, mem_req_addr, cpu_res_data, hit_count, miss_count);
        end
        rst = 1'b0;
        e = exp_q.pop_back();
        @(negedge clk);
        #2;
        total++;
        if (tag_mem[200] !== saved_tag || data_mem[200] !== saved_data) begin
            bad++; $display("FAIL reset_tag_entry got=%h exp=%h", tag_mem[200], saved_tag);
        end
        total++;
        if (mem_req_valid !== 1'b0 || cpu_res_ready !== 1'b0 || e.rw !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle got v=%b ready=%b exp=0/0", mem_req_valid, cpu_res_ready);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] d; logic ok; exp_t e;
        logic [31:0] a;
        logic        rw;
        for (int n = 0; n < 16; n++) begin
            a  = ($urandom_range(0, 3) << 14) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
            rw = 1'($urandom_range(0, 1));
            mem_delay = $urandom_range(1, 3);
            issue(rw, a, $urandom);
            wait_res(60, lat, d, ok);
            e = exp_q.pop_front();
            total++;
            if (ok !== 1'b1) begin
                bad++; $display("FAIL b2b_timeout op=%0d addr=%h got=no_response exp=response", n, a);
            end else if (!e.rw && d !== e.data) begin
                bad++; $display("FAIL b2b_read op=%0d addr=%h got=%h exp=%h", n, a, d, e.data);
            end
        end
        total++;
        if (mem_unstable !== 0 || exp_q.size() !== 0) begin
            bad++; $display("FAIL b2b_end got unstable=%0d pending=%0d exp=0/0", mem_unstable, exp_q.size());
        end
    endtask

    initial begin
        rst           = 1'b1;
        mem_clear     = 1'b1;
        cpu_req_valid = 1'b0;
        cpu_req_rw    = 1'b0;
        cpu_req_addr  = '0;
        cpu_req_data  = '0;
        repeat (2) @(negedge clk);
        mem_clear = 1'b0;
        test_reset();
        test_cold_read();
        test_read_hit();
        test_write_hit();
        test_dirty_miss();
        test_stats();
        test_reset_mid_alloc();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/dm_cache_fsm.md
# dm_cache_fsm

Controller for the direct-mapped write-back cache: accepts one CPU word request at a time, checks the tag memory, and serves hits from the cache data memory. On a miss it writes back a dirty victim line and allocates the new line from main memory. It sits directly upstream of the 512-entry × 256-bit data memory and the tag memory, driving their index, write-enable and write-data ports, and downstream of the CPU load/store port.

## Interface
- No parameters. Fixed geometry:
  - 32-bit byte address.
  - tag = addr[31:14] (18 b), index = addr[13:5] (9 b), word select = addr[4:2], addr[1:0] ignored.
  - line = 256 b = 8 × 32-bit words; word w occupies bits [32w+31:32w].
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- cpu_req_valid  in  1  CPU request present.
- cpu_req_rw  in  1  1 = write, 0 = read.
- cpu_req_addr  in  32  byte address.
- cpu_req_data  in  32  write word.
- cpu_res_ready  out  1  one-cycle completion strobe.
- cpu_res_data  out  32  read word, valid while cpu_res_ready.
- mem_req_valid  out  1  main-memory request.
- mem_req_rw  out  1  1 = line write-back, 0 = line fill.
- mem_req_addr  out  32  line-aligned address (low 5 bits zero).
- mem_req_data  out  256  victim line for write-back.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_data  in  256  fill line, valid with mem_ready on a fill.
- tag_index  out  9  tag memory index.
- tag_we  out  1  tag write enable.
- tag_write  out  20  {valid, dirty, tag[17:0]}.
- tag_read  in  20  {valid, dirty, tag[17:0]}, combinational read.
- data_index  out  9  data memory index.
- data_we  out  1  data write enable.
- data_write  out  256  line to write.
- data_read  in  256  combinational line read.
- hit_count, miss_count  out  32  statistics (see Configuration).

## Operation
- Request latch: the request fields (rw, addr, data) are captured into internal registers when cpu_req_valid=1 in IDLE. Inputs are ignored thereafter until cpu_res_ready. tag_index and data_index always equal the latched index.
- IDLE: if cpu_req_valid, latch the request and go to COMPARE_TAG; otherwise stay.
- COMPARE_TAG: hit = tag_read.valid and tag_read.tag == latched tag.
  - Read hit: cpu_res_data = selected word of data_read, cpu_res_ready=1, next state IDLE.
  - Write hit:
    - data_we=1, with data_write = data_read with the selected word replaced by the latched data.
    - tag_we=1, with tag_write = {1,1,tag}.
    - cpu_res_ready=1, next state IDLE.
  - Miss, victim clean or invalid: go to ALLOCATE.
  - Miss, victim valid and dirty: go to WRITE_BACK.
- WRITE_BACK:
  - mem_req_valid=1, mem_req_rw=1, mem_req_addr = {tag_read.tag, index, 5'b0}, mem_req_data = data_read.
  - On mem_ready, go to ALLOCATE.
- ALLOCATE:
  - mem_req_valid=1, mem_req_rw=0, mem_req_addr = {latched tag, index, 5'b0}.
  - On mem_ready: data_we=1 with data_write = mem_data; tag_we=1 with tag_write = {1,0,tag}; go to COMPARE_TAG, which then hits and completes the request, merging the word for a write.
- cpu_res_data holds the last read word outside completion cycles; 0 after reset.
- The block never initialises the tag memory; valid bits clear at tag-memory init.

## Timing
- Reset: state = IDLE, latched request = 0, and every output = 0 (cpu_res_ready, cpu_res_data, mem_req_*, tag_we, tag_write, data_we, data_write, counters).
- Reset mid-miss: the outstanding memory request is abandoned. No tag or data write occurs in the reset cycle.
- Hit latency: cpu_req_valid sampled at edge N, cpu_res_ready high for exactly cycle N+1, back in IDLE at N+2. A new request may be sampled at edge N+2.
- Clean miss: 1 (COMPARE_TAG) + k (ALLOCATE, k ≥ 1 cycles until mem_ready) + 1 (COMPARE_TAG) cycles after acceptance.
- Dirty miss: additionally m ≥ 1 WRITE_BACK cycles before ALLOCATE.
- Memory handshake:
  - mem_req_* outputs are held stable while mem_req_valid=1 and mem_ready=0.
  - mem_ready with mem_req_valid=0 is ignored.
  - After mem_ready, a WRITE_BACK→ALLOCATE request may start the next cycle.
- Outputs decode combinationally from state, latched request and memory read data. data_we/tag_we take effect at the next posedge.

## Configuration
- CACHE_STATS_EN defined:
  - hit_count increments on each COMPARE_TAG cycle that hits on the first lookup of a request.
  - miss_count increments on each first-lookup miss. The post-allocate hit is not counted.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- CACHE_STATS_EN undefined: the ports remain and are tied to 0, and no counter flops exist.

## Test plan
- Cold read of 0x0000_1004 → ALLOCATE with mem_req_addr 0x0000_1000, rw 0. Memory returns a line with word1 = 0xDEADBEEF → cpu_res_ready after the second COMPARE_TAG with cpu_res_data 0xDEADBEEF. Tag written {1,0,0x00000}.
- Repeat the read of 0x0000_1004 → cpu_res_ready exactly one cycle after acceptance, and no mem_req_valid.
- Write 0x12345678 to 0x0000_1008 (hit) → data_we with word2 replaced, tag dirty=1, 1-cycle completion.
- Read 0x0000_5008 (same index, new tag) → WRITE_BACK with addr 0x0000_1000, rw 1, data containing 0x12345678 at word2. Then ALLOCATE with addr 0x0000_5000. With a 3-cycle mem_ready delay each, completion arrives 8 cycles after acceptance.
- Assert rst during ALLOCATE → next cycle all outputs 0 and state IDLE; tag entry unchanged. With CACHE_STATS_EN, after the hit/miss sequence above then reset: hit_count 2→0, miss_count 2→0.
